// File: rtl/video_timing_pkg.sv
// Shared types and elaboration-time helpers for the video timing generator.
package video_timing_pkg;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic hblank;
        logic vblank;
        logic frame_start;
    } video_flags_t;

    // Flags describing pixel (0,0), which is also the reset state.
    localparam video_flags_t FLAGS_RESET = '{
        hsync: 1'b0, vsync: 1'b0, hblank: 1'b0, vblank: 1'b0, frame_start: 1'b1
    };

    function automatic int timing_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/video_ce_gen.sv
// Pixel clock-enable divider: ce_pix is a single-cycle pulse every CE_DIV clk_sys cycles.
module video_ce_gen
    import video_timing_pkg::*;
#(
    parameter int CE_DIV = 4
) (
    input  logic clk_sys,
    input  logic reset,
    output logic ce_pix
);

    localparam int              DW       = cnt_width(CE_DIV);
    localparam logic [DW-1:0]   DIV_LAST = DW'(CE_DIV - 1);

    logic [DW-1:0] div;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            div    <= '0;
            ce_pix <= 1'b0;
        end else begin
            ce_pix <= (div == DIV_LAST);
            div    <= (div == DIV_LAST) ? '0 : div + 1'b1;
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing source: pixel enable, sync/blank pulses and coordinates for video_mixer.
// Outputs are registered from the next counter values, so they describe the pixel being presented.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int  CE_DIV     = 4,
    parameter int  H_ACTIVE   = 640,
    parameter int  H_FP       = 16,
    parameter int  H_SYNC     = 64,
    parameter int  H_BP       = 48,
    parameter int  V_ACTIVE   = 240,
    parameter int  V_FP       = 3,
    parameter int  V_SYNC     = 3,
    parameter int  V_BP       = 16,
    parameter int  V_EXTRA    = 50,
    localparam int H_TOTAL    = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
    localparam int V_TOTAL_60 = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
    localparam int V_TOTAL_50 = V_TOTAL_60 + V_EXTRA,
    localparam int HW         = cnt_width(H_TOTAL),
    localparam int VW         = cnt_width(V_TOTAL_50)
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          mode50,
    output logic          ce_pix,
    output logic          HSync,
    output logic          VSync,
    output logic          HBlank,
    output logic          VBlank,
    output logic [HW-1:0] hcount,
    output logic [VW-1:0] vcount,
    output logic          frame_start
);

    if (CE_DIV < 1 || H_SYNC < 1 || V_SYNC < 1) begin : g_bad_params
        $error("video_timing_gen: CE_DIV must be >= 1 and sync widths must be non-zero");
    end

    localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST_60 = VW'(V_TOTAL_60 - 1);
    localparam logic [VW-1:0] V_LAST_50 = VW'(V_TOTAL_50 - 1);

    video_ce_gen #(.CE_DIV(CE_DIV)) u_ce_gen (
        .clk_sys (clk_sys),
        .reset   (reset),
        .ce_pix  (ce_pix)
    );

    logic          mode50_l;
    logic [HW-1:0] h_next;
    logic [VW-1:0] v_next;
    logic          v_wrap;
    int            h_pos;
    int            v_pos;
    video_flags_t  flags;
    video_flags_t  flags_next;

    // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        h_next     = hcount;
        v_next     = vcount;
        v_wrap     = 1'b0;
        flags_next = flags;
        if (ce_pix) begin
            if (hcount == H_LAST) begin
                h_next = '0;
                if (vcount == (mode50_l ? V_LAST_50 : V_LAST_60)) begin
                    v_next = '0;
                    v_wrap = 1'b1;
                end else begin
                    v_next = vcount + 1'b1;
                end
            end else begin
                h_next = hcount + 1'b1;
            end
        end
        h_pos = int'(h_next);
        v_pos = int'(v_next);
        flags_next.hblank      = (h_pos >= H_ACTIVE);
        flags_next.hsync       = (h_pos >= H_ACTIVE + H_FP) && (h_pos < H_ACTIVE + H_FP + H_SYNC);
        flags_next.vblank      = (v_pos >= V_ACTIVE);
        flags_next.vsync       = (v_pos >= V_ACTIVE + V_FP) && (v_pos < V_ACTIVE + V_FP + V_SYNC);
        flags_next.frame_start = (h_pos == 0) && (v_pos == 0);
    end

    // The frame-length selector only changes on the frame wrap, so a frame never changes length mid-way.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            hcount   <= '0;
            vcount   <= '0;
            mode50_l <= 1'b0;
            flags    <= FLAGS_RESET;
        end else if (ce_pix) begin
            hcount <= h_next;
            vcount <= v_next;
            flags  <= flags_next;
            if (v_wrap) begin
                mode50_l <= mode50;
            end
        end
    end

    assign HSync       = flags.hsync;
    assign VSync       = flags.vsync;
    assign HBlank      = flags.hblank;
    assign VBlank      = flags.vblank;
    assign frame_start = flags.frame_start;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: two instances (CE_DIV=2 and CE_DIV=1) checked every cycle
// against a linear pixel-index model, plus directed line/frame/reset scenarios.
module tb_video_timing_gen;

    localparam int H_ACTIVE = 4, H_FP = 1, H_SYNC = 2, H_BP = 1;
    localparam int V_ACTIVE = 3, V_FP = 1, V_SYNC = 1, V_BP = 1, V_EXTRA = 2;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int LIMIT    = 400;

    logic clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    logic       reset;
    logic       mode50;
    logic       ce [2];
    logic       hs [2];
    logic       vs [2];
    logic       hb [2];
    logic       vb [2];
    logic       fs [2];
    logic [2:0] hc [2];
    logic [2:0] vc [2];

    video_timing_gen #(
        .CE_DIV(2), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP), .V_EXTRA(V_EXTRA)
    ) dut_div2 (
        .clk_sys(clk_sys), .reset(reset), .mode50(mode50), .ce_pix(ce[0]),
        .HSync(hs[0]), .VSync(vs[0]), .HBlank(hb[0]), .VBlank(vb[0]),
        .hcount(hc[0]), .vcount(vc[0]), .frame_start(fs[0])
    );

    video_timing_gen #(
        .CE_DIV(1), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP), .V_EXTRA(V_EXTRA)
    ) dut_div1 (
        .clk_sys(clk_sys), .reset(reset), .mode50(mode50), .ce_pix(ce[1]),
        .HSync(hs[1]), .VSync(vs[1]), .HBlank(hb[1]), .VBlank(vb[1]),
        .hcount(hc[1]), .vcount(vc[1]), .frame_start(fs[1])
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: cycles since reset release, expected ce, pixel index inside the frame,
    // and the mode50 value captured at the last frame boundary.
    int ce_div [2] = '{2, 1};
    int m_cyc  [2];
    int m_pix  [2];
    bit m_ce   [2];
    bit m_lat  [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic timeout(input string tag);
        checks++;
        failures++;
        $display("FAIL timeout_%s: no DUT event within %0d cycles", tag, LIMIT);
    endtask

    function automatic int frame_pixels(input bit lat);
        return (V_ACTIVE + V_FP + V_SYNC + V_BP + (lat ? V_EXTRA : 0)) * H_TOTAL;
    endfunction

    task automatic model_edge(input int i, input logic r, input logic m);
        if (r) begin
            m_cyc[i] = 0;
            m_ce[i]  = 1'b0;
            m_pix[i] = 0;
            m_lat[i] = 1'b0;
        end else begin
            if (m_ce[i]) begin
                m_pix[i]++;
                if (m_pix[i] == frame_pixels(m_lat[i])) begin
                    m_pix[i] = 0;
                    m_lat[i] = m;
                end
            end
            m_cyc[i]++;
            m_ce[i] = (m_cyc[i] % ce_div[i]) == 0;
        end
    endtask

    task automatic compare(input int i);
        int    h;
        int    v;
        string n;
        h = m_pix[i] % H_TOTAL;
        v = m_pix[i] / H_TOTAL;
        n = (i == 0) ? "div2" : "div1";
        check({n, ".ce_pix"},      32'(ce[i]), 32'(m_ce[i]));
        check({n, ".hcount"},      32'(hc[i]), 32'(h));
        check({n, ".vcount"},      32'(vc[i]), 32'(v));
        check({n, ".HBlank"},      32'(hb[i]), 32'(h >= H_ACTIVE));
        check({n, ".HSync"},       32'(hs[i]), 32'(h >= H_ACTIVE + H_FP && h < H_ACTIVE + H_FP + H_SYNC));
        check({n, ".VBlank"},      32'(vb[i]), 32'(v >= V_ACTIVE));
        check({n, ".VSync"},       32'(vs[i]), 32'(v >= V_ACTIVE + V_FP && v < V_ACTIVE + V_FP + V_SYNC));
        check({n, ".frame_start"}, 32'(fs[i]), 32'(m_pix[i] == 0));
    endtask

    // One clk_sys edge: inputs as driven before the edge, outputs sampled 1 time unit after it.
    task automatic tick();
        logic r;
        logic m;
        r = reset;
        m = mode50;
        @(posedge clk_sys);
        #1;
        for (int i = 0; i < 2; i++) begin
            model_edge(i, r, m);
            compare(i);
        end
    endtask

    task automatic measure_frame(input bit set50, output int n,
                                 output logic [7:0] vs_map, output logic [7:0] vb_map);
        int guard;
        n      = 0;
        vs_map = '0;
        vb_map = '0;
        guard  = 0;
        while (!(ce[0] && fs[0]) && guard < LIMIT) begin
            tick();
            guard++;
        end
        if (guard >= LIMIT) begin
            timeout("frame_start");
            return;
        end
        guard = 0;
        do begin
            if (ce[0]) begin
                n++;
                if (vs[0]) vs_map[vc[0]] = 1'b1;
                if (vb[0]) vb_map[vc[0]] = 1'b1;
                if (set50 && vc[0] == 3'd2) mode50 = 1'b1;
            end
            tick();
            guard++;
        end while (!(ce[0] && fs[0]) && guard < LIMIT);
        if (guard >= LIMIT) timeout("frame_end");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         n;
        int         cnt;
        int         guard;
        logic [7:0] vs_map;
        logic [7:0] vb_map;
        logic [7:0] hb_map;
        logic [7:0] hs_map;

        reset  = 1'b1;
        mode50 = 1'b0;

        // Reset for three cycles, then the divider start-up sequence.
        repeat (3) tick();
        check("reset.frame_start", 32'(fs[0]), 32'd1);
        reset = 1'b0;
        tick();
        check("release.cycle1_ce_div2", 32'(ce[0]), 32'd0);
        check("release.cycle1_ce_div1", 32'(ce[1]), 32'd1);
        tick();
        check("release.cycle2_ce_div2", 32'(ce[0]), 32'd1);
        check("release.cycle2_origin",  32'(fs[0]), 32'd1);

        // One full line starting at pixel (0,0).
        hb_map = '0;
        hs_map = '0;
        cnt    = 0;
        guard  = 0;
        while (cnt < H_TOTAL && guard < LIMIT) begin
            if (ce[0]) begin
                hb_map[hc[0]] = hb[0];
                hs_map[hc[0]] = hs[0];
                cnt++;
            end
            tick();
            guard++;
        end
        if (guard >= LIMIT) timeout("line");
        guard = 0;
        while (!ce[0] && guard < LIMIT) begin
            tick();
            guard++;
        end
        check("line.hblank_map", 32'(hb_map), 32'h0000_00F0);
        check("line.hsync_map",  32'(hs_map), 32'h0000_0060);
        check("line.wrap_hcount", 32'(hc[0]), 32'd0);
        check("line.wrap_vcount", 32'(vc[0]), 32'd1);

        // 60 Hz frame, then a frame where mode50 rises at line 2, then the longer frame.
        measure_frame(1'b0, n, vs_map, vb_map);
        check("frame60.ce_count", 32'(n), 32'd48);
        check("frame60.vsync_lines", 32'(vs_map), 32'h10);
        check("frame60.vblank_lines", 32'(vb_map), 32'h38);
        measure_frame(1'b1, n, vs_map, vb_map);
        check("frame_switch.ce_count", 32'(n), 32'd48);
        measure_frame(1'b0, n, vs_map, vb_map);
        check("frame50.ce_count", 32'(n), 32'd64);
        check("frame50.vsync_lines", 32'(vs_map), 32'h10);
        check("frame50.vblank_lines", 32'(vb_map), 32'hF8);

        // Reset asserted at pixel (5,4) while VSync is high.
        guard = 0;
        while (!(ce[0] && hc[0] == 3'd5 && vc[0] == 3'd4) && guard < LIMIT) begin
            tick();
            guard++;
        end
        if (guard >= LIMIT) timeout("pixel_5_4");
        check("midreset.vsync_before", 32'(vs[0]), 32'd1);
        reset = 1'b1;
        tick();
        check("midreset.ce_pix", 32'(ce[0]), 32'd0);
        check("midreset.hcount", 32'(hc[0]), 32'd0);
        check("midreset.vcount", 32'(vc[0]), 32'd0);
        check("midreset.vsync",  32'(vs[0]), 32'd0);
        check("midreset.vblank", 32'(vb[0]), 32'd0);
        check("midreset.frame_start", 32'(fs[0]), 32'd1);
        reset = 1'b0;
        repeat (200) tick();

        // Random mode50 toggles and occasional resets against the model.
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 99) < 3) mode50 = ~mode50;
            reset = ($urandom_range(0, 999) < 4);
            tick();
        end
        reset = 1'b0;
        repeat (20) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
